// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator with registered sync, display-enable and line/frame pulses.
// Optional feature macro: VGA_SYNC_INTDIV_EN (internal divide-by-two advance enable instead of pix_en).
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYN_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYN_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYN_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYN_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ON   = 1'(SYNC_POL);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       adv;

`ifdef VGA_SYNC_INTDIV_EN
  logic div_q, div_d;
  logic unused_pix_en;

  assign unused_pix_en = pix_en;
  assign div_d         = ~div_q;
  // Advancing on the pre-toggle value puts the first advance on the second edge after reset.
  assign adv           = div_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= 1'b0;
    else        div_q <= div_d;
  end
`else
  assign adv = pix_en;
`endif

  // Outputs are computed from the next counter values so they land on the same edge as the counts.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (adv) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      x_d           = h_cnt_d;
      y_d           = v_cnt_d;
      de_d          = (h_cnt_d < H_ACT_END) && (v_cnt_d < V_ACT_END);
      hsync_d       = ((h_cnt_d >= H_SYN_BEG) && (h_cnt_d < H_SYN_END)) ? SYNC_ON : ~SYNC_ON;
      vsync_d       = ((v_cnt_d >= V_SYN_BEG) && (v_cnt_d < V_SYN_END)) ? SYNC_ON : ~SYNC_ON;
      line_start_d  = (h_cnt_d == '0);
      frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
